// File: rtl/image_bw_filter_pkg.sv
// Shared constants for the black/white filter stage: frame geometry,
// bus widths, FSM state encodings and the luminance helper.
package image_bw_filter_pkg;

    localparam int FB_FRAME_W  = 320;
    localparam int FB_FRAME_H  = 240;
    localparam int FB_N_PIXELS = FB_FRAME_W * FB_FRAME_H;
    localparam int FB_ADDR_W   = 17;
    localparam int FB_DATA_W   = 12;

    // FSM state encodings
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // 4-bit luminance of an RGB444 pixel: (2R + 5G + B) / 8, truncated.
    // The 7-bit sum peaks at 120, so it never overflows.
    function automatic logic [3:0] luma4(input logic [11:0] pix);
        logic [6:0] r2;
        logic [6:0] g5;
        logic [6:0] b1;
        logic [6:0] y7;
        r2 = {2'b00, pix[11:8], 1'b0};
        g5 = {3'b000, pix[7:4]} + {1'b0, pix[7:4], 2'b00};
        b1 = {3'b000, pix[3:0]};
        y7 = r2 + g5 + b1;
        return y7[6:3];
    endfunction

endpackage

// File: rtl/image_bw_filter_pix_gray_thresh.sv
// Registered pixel stage: luminance, threshold compare and output mux,
// with a valid/address side-band carried alongside the pixel.
// The channel layout assumes 12-bit {R,G,B} nibbles.
module pix_gray_thresh
    import image_bw_filter_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_pix,
    input  logic [3:0]        i_threshold,
    input  logic              i_bw_mode,
    output logic              o_valid,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_pix
);

    logic [3:0]        w_gray;
    logic              w_bin;
    logic [DATA_W-1:0] w_out;

    assign w_gray = luma4(i_pix[11:0]);
    assign w_bin  = (w_gray >= i_threshold);
    assign w_out  = i_bw_mode ? {DATA_W{w_bin}} : {3{w_gray}};

    // Register the converted pixel together with its valid bit and address.
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            o_valid <= 1'b0;
            o_addr  <= '0;
            o_pix   <= '0;
        end else begin
            o_valid <= i_valid;
            if (i_valid) begin
                o_addr <= i_addr;
                o_pix  <= w_out;
            end
        end
    end

endmodule

// File: rtl/image_bw_filter.sv
// Frame-buffer post-processing: streams one stored frame through the
// grey/threshold stage into the bw buffer, then signals done until ack.
module image_bw_filter
    import image_bw_filter_pkg::*;
#(
    parameter int N_PIXELS = FB_N_PIXELS,
    parameter int ADDR_W   = FB_ADDR_W,
    parameter int DATA_W   = FB_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              ack,
    input  logic [3:0]        threshold,
    input  logic              bw_mode,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_PIXELS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [3:0]        r_threshold;
    logic              r_bw_mode;
    logic              r_rd_vld;      // rd_data this cycle belongs to a frame pixel
    logic [ADDR_W-1:0] r_rd_addr_d;   // address that produced the current rd_data

    logic              w_last_rd;
    logic              w_last_wr;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;

    assign w_last_rd = (r_rd_addr == LAST_ADDR);
    assign w_last_wr = w_wr_en && (w_wr_addr == LAST_ADDR);

    // Control FSM, read-address counter, latched settings and read side-band.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_rd_addr   <= '0;
            r_threshold <= '0;
            r_bw_mode   <= 1'b0;
            r_rd_vld    <= 1'b0;
            r_rd_addr_d <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rd_vld <= 1'b0;
                    if (start) begin
                        r_threshold <= threshold;
                        r_bw_mode   <= bw_mode;
                        r_rd_addr   <= '0;
                        r_state     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_rd_vld    <= 1'b1;
                    r_rd_addr_d <= r_rd_addr;
                    if (w_last_rd) begin
                        r_state <= ST_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                ST_DRAIN: begin
                    r_rd_vld <= 1'b0;
                    if (w_last_wr) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_rd_vld <= 1'b0;
                    if (ack) begin
                        r_rd_addr <= '0;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_rd_vld <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

    pix_gray_thresh #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_pix (
        .clk         (clk),
        .resetn      (resetn),
        .i_valid     (r_rd_vld),
        .i_addr      (r_rd_addr_d),
        .i_pix       (rd_data),
        .i_threshold (r_threshold),
        .i_bw_mode   (r_bw_mode),
        .o_valid     (w_wr_en),
        .o_addr      (w_wr_addr),
        .o_pix       (w_wr_data)
    );

    assign rd_addr = r_rd_addr;
    assign wr_en   = w_wr_en;
    assign wr_addr = w_wr_addr;
    assign wr_data = w_wr_data;
    assign busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_image_bw_filter.sv
// Self-checking bench for image_bw_filter. Uses a short frame so several
// complete runs fit in a brief simulation; all timing scales with N_PIXELS.
module tb_image_bw_filter;

    localparam int N  = 64;
    localparam int AW = 17;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          ack;
    logic [3:0]    threshold;
    logic          bw_mode;
    logic          done;
    logic          busy;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [11:0]   fb[N];

    image_bw_filter #(
        .N_PIXELS (N),
        .ADDR_W   (AW),
        .DATA_W   (DW)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .ack       (ack),
        .threshold (threshold),
        .bw_mode   (bw_mode),
        .done      (done),
        .busy      (busy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    // Frame-buffer model with one cycle of read latency.
    always @(posedge clk) begin
        rd_data <= (int'(rd_addr) < N) ? fb[rd_addr[5:0]] : 12'hBAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference pixel conversion written straight from the arithmetic.
    function automatic logic [11:0] exp_pix(input logic [11:0] p, input logic [3:0] thr, input bit mode);
        int y;
        int g;
        y = 2 * int'(p[11:8]) + 5 * int'(p[7:4]) + int'(p[3:0]);
        g = y / 8;
        if (mode) return (g >= int'(thr)) ? 12'hFFF : 12'h000;
        return 12'(g * 'h111);
    endfunction

    task automatic push_frame(input logic [3:0] thr, input bit mode);
        for (int i = 0; i < N; i++) begin
            exp_t e;
            e.addr = AW'(i);
            e.data = exp_pix(fb[i], thr, mode);
            sb.push_back(e);
        end
    endtask

    // Write monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin : mon
        exp_t e;
        if (resetn === 1'b1 && busy === 1'b1 && done === 1'b1)
            check("busy_done_overlap", 1, 0);
        if (resetn === 1'b1 && wr_en === 1'b1) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(wr_addr), 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(e.addr));
                check("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic start_run(input logic [3:0] thr, input bit mode);
        @(negedge clk);
        threshold = thr;
        bw_mode   = mode;
        start     = 1'b1;
        wr_cnt    = 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        check("rd_addr_first", 32'(rd_addr), 0);
    endtask

    // Waits (bounded) for done; optionally disturbs threshold/start mid-run.
    task automatic wait_done(input bit disturb);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (n < N + 50 && !seen) begin
            @(posedge clk);
            #1;
            n++;
            if (done === 1'b1) begin
                seen = 1'b1;
            end else begin
                check("busy_in_run", 32'(busy), 1);
                check("rd_addr_seq", 32'(rd_addr), 32'((n < N - 1) ? n : N - 1));
                if (disturb && n == 5) begin
                    threshold = 4'hF;
                    start     = 1'b1;
                end
                if (disturb && n == 6) start = 1'b0;
            end
        end
        check("done_edge", 32'(n), 32'(N + 2));
        check("wr_count", 32'(wr_cnt), 32'(N));
        check("sb_drained", 32'(sb.size()), 0);
        check("busy_at_done", 32'(busy), 0);
        check("rd_addr_hold", 32'(rd_addr), 32'(N - 1));
    endtask

    task automatic ack_pulse();
        @(negedge clk);
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
        check("done_after_ack", 32'(done), 0);
        check("busy_after_ack", 32'(busy), 0);
        check("rd_addr_idle", 32'(rd_addr), 0);
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        ack       = 1'b0;
        threshold = 4'd0;
        bw_mode   = 1'b0;
        for (int i = 0; i < N; i++) fb[i] = 12'h000;

        // Reset values
        #23;
        check("rst_done", 32'(done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_rd_addr", 32'(rd_addr), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        @(negedge clk);
        resetn = 1'b1;

        // Grey mode over an all-red frame: every output 12'h333
        for (int i = 0; i < N; i++) fb[i] = 12'hF00;
        push_frame(4'd0, 1'b0);
        start_run(4'd0, 1'b0);
        wait_done(1'b0);

        // done held while ack stays low, with no writes
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            check("done_held", 32'(done), 1);
        end
        check("no_writes_in_done", 32'(wr_cnt), 32'(N));
        ack_pulse();

        // Binary mode, threshold 8: gray 9 at pixel 13, gray exactly 8 at 20,
        // gray 1 elsewhere. Threshold change and start pulse mid-run ignored.
        for (int i = 0; i < N; i++) fb[i] = 12'h00F;
        fb[13] = 12'h0F0;
        fb[20] = 12'h0D0;
        push_frame(4'd8, 1'b1);
        start_run(4'd8, 1'b1);
        wait_done(1'b1);
        ack_pulse();

        // Same frame, threshold 9: the gray-8 pixel now goes black
        push_frame(4'd9, 1'b1);
        start_run(4'd9, 1'b1);
        wait_done(1'b0);
        ack_pulse();

        // Reset mid-frame drops outputs asynchronously
        for (int i = 0; i < N; i++) fb[i] = 12'($urandom_range(0, 4095));
        push_frame(4'd5, 1'b0);
        start_run(4'd5, 1'b0);
        repeat (20) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_wr_en", 32'(wr_en), 0);
        check("arst_busy", 32'(busy), 0);
        check("arst_done", 32'(done), 0);
        check("arst_rd_addr", 32'(rd_addr), 0);
        sb.delete();
        @(negedge clk);
        #1;
        resetn = 1'b1;

        // Next run restarts from address 0
        push_frame(4'd5, 1'b0);
        start_run(4'd5, 1'b0);
        wait_done(1'b0);

        // start held high through ack: a new run begins from IDLE
        push_frame(4'd5, 1'b0);
        @(negedge clk);
        start = 1'b1;
        ack   = 1'b1;
        @(posedge clk);
        #1;
        ack    = 1'b0;
        wr_cnt = 0;
        check("level_idle_done", 32'(done), 0);
        check("level_idle_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("level_restart_busy", 32'(busy), 1);
        wait_done(1'b0);
        ack_pulse();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
